// File: rtl/ttl_pkg.sv
// ---------------------------------------------------------------------------
// ttl_pkg
//   Shared definitions for the clocked TTL gate bank.
//   - TTL_* gate-function codes used by the MODE parameter
//   - ttl_identity  : input value that leaves a gate's reduction unchanged
//   - ttl_eval      : reduce up to TTL_MAX_INPUTS bits with a gate function
//   - ttl_reset_val : gate result for all-zero inputs (reset value of state)
//   Unknown mode codes behave as NAND in every helper.
// ---------------------------------------------------------------------------
package ttl_pkg;

  localparam int TTL_NAND = 0;
  localparam int TTL_AND  = 1;
  localparam int TTL_NOR  = 2;
  localparam int TTL_OR   = 3;
  localparam int TTL_XOR  = 4;
  localparam int TTL_XNOR = 5;

  // Widest gate supported; narrower gates pad the unused bits with the identity.
  localparam int TTL_MAX_INPUTS = 16;

  // Value a masked input is replaced with so it cannot influence the result.
  function automatic logic ttl_identity(input int mode);
    case (mode)
      TTL_AND, TTL_NAND:                  return 1'b1;
      TTL_NOR, TTL_OR, TTL_XOR, TTL_XNOR: return 1'b0;
      default:                            return 1'b1;
    endcase
  endfunction

  function automatic logic ttl_eval(input int mode,
                                    input logic [TTL_MAX_INPUTS-1:0] bits);
    case (mode)
      TTL_AND:  return  &bits;
      TTL_NOR:  return ~|bits;
      TTL_OR:   return  |bits;
      TTL_XOR:  return  ^bits;
      TTL_XNOR: return ~^bits;
      default:  return ~&bits;
    endcase
  endfunction

  // All-zero inputs give a result independent of gate width, so the padded
  // evaluation is exact for any INPUTS.
  function automatic logic ttl_reset_val(input int mode);
    return ttl_eval(mode, '0);
  endfunction

endpackage : ttl_pkg

// File: rtl/ttl_glitch_filter.sv
// ---------------------------------------------------------------------------
// ttl_glitch_filter
//   One channel's glitch filter. A new value of d is accepted into the held
//   bit only after it has differed from the held bit on FILTER consecutive
//   ce cycles; any ce cycle where d matches the held bit restarts the count.
//   FILTER = 0 bypasses the filter (q follows d combinationally).
// Ports
//   clk_sys  in  system clock
//   reset_n  in  asynchronous active-low reset (held <= RESET_VAL, count <= 0)
//   ce       in  clock enable; state advances only when 1
//   d        in  unfiltered gate result
//   q        out filtered (held) value
// ---------------------------------------------------------------------------
module ttl_glitch_filter #(
  parameter int   FILTER    = 0,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce,
  input  logic d,
  output logic q
);

  generate
    if (FILTER == 0) begin : g_bypass
      // Clock, reset and enable have no function when the filter is bypassed.
      logic bypass_unused;
      assign bypass_unused = ^{clk_sys, reset_n, ce};
      assign q = d;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER + 1);

      logic [CW-1:0] cnt;
      logic          held;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          cnt  <= '0;
          held <= RESET_VAL;
        end else if (ce) begin
          if (d == held) begin
            cnt <= '0;
          end else if (cnt == CW'(FILTER - 1)) begin
            // This is the FILTER-th consecutive differing sample: accept it.
            held <= d;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end

      assign q = held;
    end
  endgenerate

endmodule : ttl_glitch_filter

// File: rtl/ttl_gate_bank.sv
// ---------------------------------------------------------------------------
// ttl_gate_bank
//   Bank of CHANNELS independent INPUTS-wide logic gates with per-input
//   masking, optional input synchroniser, per-channel glitch filter,
//   DELAY-deep output pipeline and edge-pulse outputs. All state advances
//   only on clk_sys edges where ce = 1.
// Ports
//   clk_sys  in  system clock (single domain)
//   reset_n  in  asynchronous active-low reset
//   ce       in  clock enable
//   in       in  [CHANNELS*INPUTS] gate inputs, channel c = [c*INPUTS +: INPUTS]
//   en_mask  in  [CHANNELS*INPUTS] 1 = input used, 0 = replaced by identity
//   y_comb   out [CHANNELS] unregistered gate result of synchronised inputs
//   y        out [CHANNELS] filtered, delayed gate output
//   y_rise   out [CHANNELS] pulse for one ce cycle after y goes 0->1
//   y_fall   out [CHANNELS] pulse for one ce cycle after y goes 1->0
// ---------------------------------------------------------------------------
module ttl_gate_bank
  import ttl_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int INPUTS      = 8,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 0,
  parameter int FILTER      = 0,
  parameter int DELAY       = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic [CHANNELS*INPUTS-1:0]   in,
  input  logic [CHANNELS*INPUTS-1:0]   en_mask,
  output logic [CHANNELS-1:0]          y_comb,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          y_rise,
  output logic [CHANNELS-1:0]          y_fall
);

  localparam int   N        = CHANNELS * INPUTS;
  localparam logic IDENT    = ttl_identity(MODE);
  localparam logic RST_VAL  = ttl_reset_val(MODE);

  // -------------------------------------------------------------------------
  // Input synchroniser
  // -------------------------------------------------------------------------
  logic [N-1:0] sync_out;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign sync_out = in;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          // NOTE: this array is a handful of real flops, not a RAM, so it is
          // safe (and required) to reset every entry.
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else if (ce) begin
          // NOTE: non-blocking assignments let every stage sample the value
          // its predecessor held before this edge, forming a true shift chain.
          sync_q[0] <= in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Per-channel gate, filter, delay pipeline and edge detect
  // -------------------------------------------------------------------------
  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [TTL_MAX_INPUTS-1:0] bits;
      logic [INPUTS-1:0]         ch_in;
      logic [INPUTS-1:0]         ch_mask;
      logic                      held;
      logic [DELAY-1:0]          pipe;
      logic                      y_prev;

      assign ch_in   = sync_out[c*INPUTS +: INPUTS];
      assign ch_mask = en_mask[c*INPUTS +: INPUTS];

      always_comb begin
        // NOTE: every bit gets a default first so no path leaves bits
        // unassigned, which would otherwise infer a latch.
        bits = {TTL_MAX_INPUTS{IDENT}};
        bits[INPUTS-1:0] = (ch_in & ch_mask) | (~ch_mask & {INPUTS{IDENT}});
      end

      assign y_comb[c] = ttl_eval(MODE, bits);

      ttl_glitch_filter #(
        .FILTER    (FILTER),
        .RESET_VAL (RST_VAL)
      ) u_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .d       (y_comb[c]),
        .q       (held)
      );

      // pipe[0] is the newest sample; y is the oldest stage.
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          pipe   <= {DELAY{RST_VAL}};
          y_prev <= RST_VAL;
        end else if (ce) begin
          pipe   <= (pipe << 1) | DELAY'(held);
          y_prev <= pipe[DELAY-1];
        end
      end

      assign y[c] = pipe[DELAY-1];

      // y_prev is y one ce cycle earlier; gating with ce keeps the pulse to
      // exactly one ce cycle and zero while the bank is stalled.
      assign y_rise[c] = ce &  pipe[DELAY-1] & ~y_prev;
      assign y_fall[c] = ce & ~pipe[DELAY-1] &  y_prev;
    end
  endgenerate

endmodule : ttl_gate_bank

// File: tb/tb_ttl_gate_bank.sv
// ---------------------------------------------------------------------------
// tb_ttl_gate_bank
//   Directed bench for ttl_gate_bank. Several instances with different
//   parameter sets run side by side from one clock; each sequence below
//   drives its own instance. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ttl_gate_bank;
  import ttl_pkg::*;

  localparam int CH = 4;
  localparam int IN = 8;
  localparam int N  = CH * IN;
  localparam int NID = 7;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic reset_n;
  logic reset_x;
  logic ce_one;
  logic [N-1:0] mask_all;

  int checks = 0;
  int errors = 0;

  // NAND (default timing) and OR (DELAY=2) share inputs
  logic          ce_a;
  logic [N-1:0]  in_a, mask_a;
  logic [CH-1:0] yc_n, y_n, yr_n, yf_n;
  logic [CH-1:0] yc_o, y_o, yr_o, yf_o;
  // AND with FILTER=3
  logic [N-1:0]  in_f;
  logic [CH-1:0] yc_f, y_f, yr_f, yf_f;
  // XOR with SYNC_STAGES=2, DELAY=4, throttled ce
  logic          ce_s;
  logic [N-1:0]  in_s;
  logic [CH-1:0] yc_s, y_s, yr_s, yf_s;
  // XNOR with S=1, F=2, D=2, own reset
  logic [N-1:0]  in_x;
  logic [CH-1:0] yc_x, y_x, yr_x, yf_x;
  // All-masked instances, one per mode (last one uses an undefined mode)
  logic [N-1:0]  in_id, mask_id;
  logic [CH-1:0] yc_id [NID];
  logic [CH-1:0] y_id  [NID];
  logic [CH-1:0] yr_id [NID];
  logic [CH-1:0] yf_id [NID];

  ttl_gate_bank #(.CHANNELS(CH), .INPUTS(IN), .MODE(TTL_NAND)) u_nand (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce_a), .in(in_a), .en_mask(mask_a),
    .y_comb(yc_n), .y(y_n), .y_rise(yr_n), .y_fall(yf_n));

  ttl_gate_bank #(.CHANNELS(CH), .INPUTS(IN), .MODE(TTL_OR), .DELAY(2)) u_or (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce_a), .in(in_a), .en_mask(mask_a),
    .y_comb(yc_o), .y(y_o), .y_rise(yr_o), .y_fall(yf_o));

  ttl_gate_bank #(.CHANNELS(CH), .INPUTS(IN), .MODE(TTL_AND), .FILTER(3), .DELAY(1)) u_and_f (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce_one), .in(in_f), .en_mask(mask_all),
    .y_comb(yc_f), .y(y_f), .y_rise(yr_f), .y_fall(yf_f));

  ttl_gate_bank #(.CHANNELS(CH), .INPUTS(IN), .MODE(TTL_XOR), .SYNC_STAGES(2), .DELAY(4)) u_xor_s (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce_s), .in(in_s), .en_mask(mask_all),
    .y_comb(yc_s), .y(y_s), .y_rise(yr_s), .y_fall(yf_s));

  ttl_gate_bank #(.CHANNELS(CH), .INPUTS(IN), .MODE(TTL_XNOR), .SYNC_STAGES(1), .FILTER(2), .DELAY(2)) u_xnor_r (
    .clk_sys(clk_sys), .reset_n(reset_x), .ce(ce_one), .in(in_x), .en_mask(mask_all),
    .y_comb(yc_x), .y(y_x), .y_rise(yr_x), .y_fall(yf_x));

  for (genvar g = 0; g < NID; g++) begin : g_id
    ttl_gate_bank #(.CHANNELS(CH), .INPUTS(IN), .MODE((g < 6) ? g : 7)) u_id (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce_one), .in(in_id), .en_mask(mask_id),
      .y_comb(yc_id[g]), .y(y_id[g]), .y_rise(yr_id[g]), .y_fall(yf_id[g]));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]  in;
    logic [N-1:0]  mask;
    logic [CH-1:0] exp_nand;
    logic [CH-1:0] exp_or;
  } vec_t;

  vec_t vecs [8];

  // Results for all inputs masked, and for all-zero inputs (reset value),
  // indexed by instance: NAND, AND, NOR, OR, XOR, XNOR, undefined(=NAND).
  logic id_ref  [NID];
  logic rst_ref [NID];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 4'h0};
    vecs[1] = '{32'h0000_00FF, 32'hFFFF_FFFF, 4'hE, 4'h1};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 4'hF};
    vecs[3] = '{32'h7FFF_01FF, 32'hFFFF_FFFF, 4'hA, 4'hF};
    vecs[4] = '{32'h0000_00F0, 32'hFFFF_FF0F, 4'hF, 4'h0};
    vecs[5] = '{32'hFFFF_FF0F, 32'hFFFF_FF0F, 4'h0, 4'hF};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 4'h0, 4'h0};
    vecs[7] = '{32'h00FF_0000, 32'hFF00_FFFF, 4'hB, 4'h0};

    id_ref  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rst_ref = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    reset_n  = 1'b0;
    reset_x  = 1'b0;
    ce_one   = 1'b1;
    mask_all = '1;
    ce_a     = 1'b1;
    in_a     = '0;
    mask_a   = '1;
    in_f     = '0;
    ce_s     = 1'b0;
    in_s     = '0;
    in_x     = '0;
    in_id    = '1;
    mask_id  = '0;

    #12;
    reset_n = 1'b1;
    reset_x = 1'b1;
    #1;

    // Reset values, before any clock edge
    check("nand_reset_y", y_n, 4'hF);
    check("nand_reset_rise", yr_n, 4'h0);
    check("nand_reset_fall", yf_n, 4'h0);
    check("and_f_reset_y", y_f, 4'h0);
    check("xnor_reset_y", y_x, 4'hF);
    for (int m = 0; m < NID; m++) begin
      check($sformatf("reset_y_mode%0d", m), y_id[m], {CH{rst_ref[m]}});
      check($sformatf("ident_comb_mode%0d", m), yc_id[m], {CH{id_ref[m]}});
    end
    tick();
    for (int m = 0; m < NID; m++)
      check($sformatf("ident_y_mode%0d", m), y_id[m], {CH{id_ref[m]}});

    // NAND: all ones on channel 0, one-cycle drop-in timing
    in_a = 32'h0000_00FF;
    #1;
    check("nand_y_before_edge", y_n, 4'hF);
    tick();
    check("nand_y_ch0_low", y_n, 4'hE);
    check("nand_fall_pulse", yf_n, 4'h1);
    check("nand_no_rise", yr_n, 4'h0);
    tick();
    check("nand_fall_once", yf_n, 4'h0);
    check("nand_y_hold", y_n, 4'hE);

    // Table: combinational result for NAND and OR, registered NAND
    for (int i = 0; i < 8; i++) begin
      in_a   = vecs[i].in;
      mask_a = vecs[i].mask;
      #1;
      check($sformatf("tbl%0d_nand_comb", i), yc_n, vecs[i].exp_nand);
      check($sformatf("tbl%0d_or_comb", i), yc_o, vecs[i].exp_or);
      tick();
      check($sformatf("tbl%0d_nand_y", i), y_n, vecs[i].exp_nand);
    end

    // OR with masking on channel 0, DELAY=2
    mask_a = 32'hFFFF_FF0F;
    in_a   = 32'h0000_00F0;
    repeat (3) tick();
    check("or_masked_comb", yc_o, 4'h0);
    check("or_masked_y", y_o, 4'h0);
    in_a = 32'h0000_0001;
    tick();
    check("or_delay1_y", y_o, 4'h0);
    check("or_delay1_rise", yr_o, 4'h0);
    tick();
    check("or_delay2_y", y_o, 4'h1);
    check("or_rise_pulse", yr_o, 4'h1);
    tick();
    check("or_rise_once", yr_o, 4'h0);

    // AND with FILTER=3: 2-cycle pulse rejected
    in_f = 32'h0000_00FF;
    tick();
    check("filt_short_y1", y_f, 4'h0);
    tick();
    check("filt_short_y2", y_f, 4'h0);
    in_f = '0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("filt_short_y", y_f, 4'h0);
      check("filt_short_edges", {yr_f, yf_f}, 8'h00);
    end
    // 3-cycle pulse accepted, y at 4th ce cycle
    in_f = 32'h0000_00FF;
    for (int t = 1; t <= 3; t++) begin
      tick();
      check($sformatf("filt_long_y_t%0d", t), y_f, 4'h0);
    end
    tick();
    check("filt_long_y_t4", y_f, 4'h1);
    check("filt_long_rise", yr_f, 4'h1);
    in_f = '0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      check($sformatf("filt_release_y_t%0d", t), y_f, 4'h1);
    end
    tick();
    check("filt_release_y_t4", y_f, 4'h0);
    check("filt_release_fall", yf_f, 4'h1);

    // XOR with SYNC_STAGES=2, DELAY=4, ce high one clock in three
    in_s = 32'h0000_0001;
    for (int k = 1; k <= 8; k++) begin
      ce_s = 1'b1;
      #1;
      check($sformatf("sync_rise_k%0d", k), yr_s, (k == 7) ? 4'h1 : 4'h0);
      check($sformatf("sync_fall_k%0d", k), yf_s, 4'h0);
      tick();
      ce_s = 1'b0;
      #1;
      for (int p = 0; p < 2; p++) begin
        check($sformatf("sync_y_k%0d", k), y_s, (k >= 6) ? 4'h1 : 4'h0);
        check($sformatf("sync_comb_k%0d", k), yc_s, (k >= 2) ? 4'h1 : 4'h0);
        check($sformatf("sync_stall_pulses_k%0d", k), {yr_s, yf_s}, 8'h00);
        tick();
      end
    end

    // XNOR: asynchronous reset mid-pipeline and mid-filter
    in_x = 32'h0000_0001;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check($sformatf("xnor_lat_y_t%0d", t), y_x, 4'hF);
    end
    tick();
    check("xnor_lat_y_t5", y_x, 4'hE);
    check("xnor_lat_fall", yf_x, 4'h1);
    in_x = 32'h0000_0101;
    tick();
    tick();
    #2;
    reset_x = 1'b0;
    #1;
    check("xnor_async_reset_y", y_x, 4'hF);
    check("xnor_async_reset_edges", {yr_x, yf_x}, 8'h00);
    @(posedge clk_sys);
    #3;
    reset_x = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk_sys);
      #1;
      check($sformatf("xnor_post_reset_y_t%0d", t), y_x, 4'hF);
    end
    @(posedge clk_sys);
    #1;
    check("xnor_post_reset_y_t5", y_x, 4'hC);
    check("xnor_post_reset_fall", yf_x, 4'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ttl_gate_bank

// File: doc/ttl_gate_bank.md
# ttl_gate_bank

Parametrised bank of multi-input logic gates for discrete-logic recreations. It is the clocked successor to the fixed 8-input NAND package: configurable channel count, input count and gate function, with per-input masking, an optional input synchroniser, a per-channel glitch filter, a propagation-delay pipeline and edge-pulse outputs. It is used wherever board-level gates feed clocked logic and the original gate's timing or hazard behaviour has to be reproduced.

## Interface
- CHANNELS, 4, number of independent gates (1..16)
- INPUTS, 8, inputs per gate (2..16)
- MODE, 0, gate function: 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR
- SYNC_STAGES, 0, synchroniser flops per input (0..3)
- FILTER, 0, consecutive ce cycles a new value must hold before it is accepted (0 = filter bypassed, max 15)
- DELAY, 1, output pipeline depth in ce cycles (1..8)

Ports:
- clk_sys  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; all state advances only when ce=1
- in  in  CHANNELS*INPUTS  gate inputs; channel c uses bits [c*INPUTS +: INPUTS]
- en_mask  in  CHANNELS*INPUTS  1 = input participates; 0 = input is replaced by the identity value (1 for AND/NAND, 0 for OR/NOR/XOR/XNOR)
- y_comb  out  CHANNELS  unregistered gate result of synchronised, masked inputs
- y  out  CHANNELS  filtered, delayed gate output
- y_rise  out  CHANNELS  one-cycle pulse when y goes 0->1
- y_fall  out  CHANNELS  one-cycle pulse when y goes 1->0

## Operation
- Reset value of y and of every pipeline/filter-held bit is the gate's result for all-zero inputs: NAND 1, AND 0, NOR 1, OR 0, XOR 0, XNOR 1. Synchroniser flops reset to 0. Filter counters, y_rise and y_fall reset to 0.
- Reset asserted mid-operation forces all of the above to their reset values immediately, irrespective of ce.
- Synchroniser: SYNC_STAGES flops per input bit, advancing on ce. With 0 stages, in feeds the gate directly.
- Gate evaluation: masked inputs are reduced per MODE. All inputs masked gives the identity result: NAND 0, AND 1, NOR 1, OR 0, XOR 0, XNOR 1.
- Glitch filter (per channel, FILTER>0): a held bit and a counter of width $clog2(FILTER+1).
  - On each ce with y_comb != held, the counter increments.
  - When the counter would reach FILTER, held takes y_comb and the counter clears.
  - On any ce with y_comb == held, the counter clears. Pulses shorter than FILTER ce cycles are discarded.
  - FILTER=0: held equals y_comb combinationally.
- Delay: a DELAY-deep shift register per channel fed from held, advancing on ce. y is the last stage.
- Edges: y_rise/y_fall compare y with its value one ce cycle earlier. Both are 0 whenever ce=0. Never both 1 on one channel.
- ce=0 freezes the synchroniser, counters, pipeline and y. y_comb still follows the synchroniser outputs.
- Unknown MODE values behave as NAND.

## Timing
- Latency from an in change sampled at ce-cycle k to y: S + F + D ce cycles, with S = SYNC_STAGES, F = FILTER, D = DELAY.
- y_rise/y_fall are asserted in the same clk_sys cycle that y changes, and last exactly one ce cycle.
- y_comb latency is S ce cycles.
- With ce tied to 1 and S=F=0, D=1, y equals y_comb registered once. This is the drop-in timing of a clocked TTL gate.
- Channels are fully independent. Simultaneous changes on several channels give independent, same-cycle responses.

## Structure
- Shared package ttl_pkg:
  - MODE constants: TTL_NAND, TTL_AND, TTL_NOR, TTL_OR, TTL_XOR, TTL_XNOR.
  - Function ttl_identity(mode).
  - Function ttl_reset_val(mode).
  - Function ttl_eval(mode, bits).
- Sub-module ttl_glitch_filter: one channel's counter and held bit, parameter FILTER. Instantiated CHANNELS times with a generate loop.
- Synchroniser, delay pipeline and edge detect stay inline in ttl_gate_bank.

## Test plan
- MODE=0, INPUTS=8, all en_mask=1. Reset gives y=1. Drive all ones on channel 0: y[0]=0 after 1 ce cycle, y_fall[0] pulses once, other channels stay 1.
- MODE=3, en_mask=0x0F on a channel, in=0xF0: y=0 (masked inputs ignored). Then in=0x01: y=1 after DELAY cycles, y_rise pulses.
- FILTER=3, DELAY=1, MODE=1. A 2-ce-cycle all-ones pulse leaves y at 0 with no edge pulses. A 3-cycle pulse sets y=1 exactly 4 ce cycles after the first sample.
- SYNC_STAGES=2, DELAY=4, ce toggling 1-of-3: latency is exactly 6 ce cycles. y, y_rise and y_fall are frozen and pulses are 0 during ce=0.
- Assert reset_n=0 mid-filter-count and mid-pipeline, MODE=5: y returns to 1 asynchronously with counters 0. After release, a new input needs the full S+F+D cycles.
- All inputs masked per MODE: y equals the identity result from the Operation section for each of the six modes.
